// File: rtl/sram_resp_pkg.sv
// Shared constants for the SRAM-like data-port responder: MMIO offsets, register reset
// values, bus widths and a byte-enable merge helper.
package sram_resp_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = DataW / 8;

  // MMIO register offsets within the 64 KB MMIO window.
  localparam logic [15:0] OffScratch = 16'h0000;
  localparam logic [15:0] OffLed     = 16'h0004;
  localparam logic [15:0] OffCount   = 16'h0008;
  localparam logic [15:0] OffCompare = 16'h000C;
  localparam logic [15:0] OffStatus  = 16'h0010;

  // Register reset values (COMPARE reset comes from the CMP_RST parameter).
  localparam logic [DataW-1:0] ScratchRst = '0;
  localparam logic [15:0]      LedRst     = '0;
  localparam logic [DataW-1:0] CountRst   = '0;

  typedef enum logic {
    RegionRam,
    RegionMmio
  } region_e;

  // Replace the bytes of old_v selected by be with the matching bytes of new_v.
  function automatic logic [DataW-1:0] apply_be(logic [DataW-1:0] old_v,
                                                logic [DataW-1:0] new_v,
                                                logic [BeW-1:0]   be);
    logic [DataW-1:0] res;
    res = old_v;
    for (int i = 0; i < BeW; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_resp_if.sv
// SRAM-like data interface between the core (master) and a responder (slave).
interface sram_resp_if;
  import sram_resp_pkg::*;

  logic             en;
  logic [BeW-1:0]   wen;
  logic [AddrW-1:0] addr;
  logic [DataW-1:0] wdata;
  logic [DataW-1:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);

endinterface

// File: rtl/sram_resp_timer.sv
// Free-running COUNT, COMPARE and the pending flag; a COUNT==COMPARE match sets pending.
module sram_resp_timer
  import sram_resp_pkg::*;
#(
  parameter logic [DataW-1:0] CMP_RST = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_we,
  input  logic             compare_we,
  input  logic             status_we,
  input  logic [BeW-1:0]   be,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] count,
  output logic [DataW-1:0] compare,
  output logic             pending
);

  logic [DataW-1:0] count_q, count_d;
  logic [DataW-1:0] compare_q, compare_d;
  logic             pending_q, pending_d;

  // Next state: a COUNT write replaces the increment; a match beats a clear.
  always_comb begin
    count_d   = count_we ? apply_be(count_q, wdata, be) : count_q + 32'd1;
    compare_d = compare_we ? apply_be(compare_q, wdata, be) : compare_q;
    pending_d = pending_q;
    if (status_we && be[0] && wdata[0]) pending_d = 1'b0;
    if (count_q == compare_q) pending_d = 1'b1;
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= CountRst;
      compare_q <= CMP_RST;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign pending = pending_q;

endmodule

// File: rtl/sram_resp.sv
// Responder for the core's SRAM-like data port: word RAM plus a small MMIO block
// (scratch, LED, and timer registers when SRAM_RESP_TIMER_EN is defined). 1-cycle reads.
module sram_resp
  import sram_resp_pkg::*;
#(
  parameter int unsigned      ADDR_W  = 14,
  parameter logic [15:0]      MMIO_HI = 16'hBFAF,
  parameter logic [DataW-1:0] CMP_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  sram_resp_if.slave  bus,
  output logic [15:0] led,
  output logic        timer_int
);

  logic [DataW-1:0] mem [2**ADDR_W];

  logic [DataW-1:0] rdata_q, scratch_q, mmio_rdata;
  logic [15:0]      led_q;
  logic [15:0]      off;
  logic [ADDR_W-1:0] idx;
  region_e          region;
  logic             rd, wr, mmio_wr, ram_we;
  logic             unused_addr;

  assign unused_addr = ^bus.addr[1:0];
  assign off    = bus.addr[15:0];
  assign idx    = bus.addr[ADDR_W+1:2];
  assign region = (bus.addr[31:16] == MMIO_HI) ? RegionMmio : RegionRam;
  // Requests sampled together with reset are dropped.
  assign rd      = bus.en && (bus.wen == '0) && !rst;
  assign wr      = bus.en && (bus.wen != '0) && !rst;
  assign mmio_wr = wr && (region == RegionMmio);
  assign ram_we  = wr && (region == RegionRam);

`ifdef SRAM_RESP_TIMER_EN
  logic [DataW-1:0] count, compare;
  logic             pending;

  sram_resp_timer #(
    .CMP_RST (CMP_RST)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mmio_wr && (off == OffCount)),
    .compare_we (mmio_wr && (off == OffCompare)),
    .status_we  (mmio_wr && (off == OffStatus)),
    .be         (bus.wen),
    .wdata      (bus.wdata),
    .count      (count),
    .compare    (compare),
    .pending    (pending)
  );

  assign timer_int = pending;
`else
  assign timer_int = 1'b0;
`endif

  // MMIO read mux; unmapped offsets read zero.
  always_comb begin
    mmio_rdata = '0;
    case (off)
      OffScratch: mmio_rdata = scratch_q;
      OffLed:     mmio_rdata = {16'h0000, led_q};
`ifdef SRAM_RESP_TIMER_EN
      OffCount:   mmio_rdata = count;
      OffCompare: mmio_rdata = compare;
      OffStatus:  mmio_rdata = {31'd0, pending};
`endif
      default:    mmio_rdata = '0;
    endcase
  end

  // RAM byte writes; contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < BeW; i++) begin
        if (bus.wen[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Registered read data, held until the next read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd) begin
      rdata_q <= (region == RegionMmio) ? mmio_rdata : mem[idx];
    end
  end

  // Scratch and LED registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q <= ScratchRst;
      led_q     <= LedRst;
    end else if (mmio_wr) begin
      if (off == OffScratch) scratch_q <= apply_be(scratch_q, bus.wdata, bus.wen);
      if (off == OffLed) begin
        if (bus.wen[0]) led_q[7:0]  <= bus.wdata[7:0];
        if (bus.wen[1]) led_q[15:8] <= bus.wdata[15:8];
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign led       = led_q;

endmodule

// File: tb/tb_sram_resp.sv
// Directed self-checking bench for sram_resp; timer checks follow SRAM_RESP_TIMER_EN.
module tb_sram_resp;

  logic        clk;
  logic        rst;
  logic [15:0] led;
  logic        timer_int;
  int          n_tests;
  int          n_fail;

  sram_resp_if bus ();

  sram_resp dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .led       (led),
    .timer_int (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request, then return 1 time unit after the edge that sampled it.
  task automatic req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    bus.en    = 1'b1;
    bus.wen   = wen;
    bus.addr  = addr;
    bus.wdata = wdata;
    @(posedge clk);
    #1;
    bus.en  = 1'b0;
    bus.wen = 4'h0;
  endtask

  task automatic idle(input int n);
    bus.en  = 1'b0;
    bus.wen = 4'h0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.wen   = 4'h0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_rdata", bus.rdata, 32'h0);
    check_eq("rst_led", {16'h0, led}, 32'h0);
    check_eq("rst_timer_int", {31'h0, timer_int}, 32'h0);

    // RAM write then read
    req(4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
    check_eq("wr_keeps_rdata", bus.rdata, 32'h0);
    req(4'h0, 32'h0000_0100, 32'h0);
    check_eq("rd_full_word", bus.rdata, 32'hDEAD_BEEF);
    idle(3);
    check_eq("rdata_hold_idle", bus.rdata, 32'hDEAD_BEEF);

    // Byte-lane write
    req(4'b0010, 32'h0000_0100, 32'h0000_5500);
    check_eq("byte_wr_keeps_rdata", bus.rdata, 32'hDEAD_BEEF);
    req(4'h0, 32'h0000_0100, 32'h0);
    check_eq("rd_byte_write", bus.rdata, 32'hDEAD_55EF);

    // Upper address bits alias onto the same word
    req(4'h0, 32'h0001_0100, 32'h0);
    check_eq("rd_alias", bus.rdata, 32'hDEAD_55EF);

    // Back-to-back reads of different words
    req(4'hF, 32'h0000_0104, 32'h0102_0304);
    req(4'h0, 32'h0000_0104, 32'h0);
    check_eq("b2b_rd0", bus.rdata, 32'h0102_0304);
    req(4'h0, 32'h0000_0100, 32'h0);
    check_eq("b2b_rd1", bus.rdata, 32'hDEAD_55EF);

    // LED register: upper half not stored
    req(4'hF, 32'hBFAF_0004, 32'h1234_ABCD);
    check_eq("led_out", {16'h0, led}, 32'h0000_ABCD);
    req(4'h0, 32'hBFAF_0004, 32'h0);
    check_eq("rd_led", bus.rdata, 32'h0000_ABCD);

    // Unmapped offset
    req(4'hF, 32'hBFAF_0020, 32'hFFFF_FFFF);
    req(4'h0, 32'hBFAF_0020, 32'h0);
    check_eq("rd_unmapped", bus.rdata, 32'h0);

    // Scratch with a partial write
    req(4'hF, 32'hBFAF_0000, 32'hCAFE_F00D);
    req(4'b1000, 32'hBFAF_0000, 32'h1100_0000);
    req(4'h0, 32'hBFAF_0000, 32'h0);
    check_eq("rd_scratch", bus.rdata, 32'h11FE_F00D);

`ifdef SRAM_RESP_TIMER_EN
    req(4'h0, 32'hBFAF_000C, 32'h0);
    check_eq("rd_compare_rst", bus.rdata, 32'hFFFF_FFFF);
    // COMPARE=5, COUNT=0: pending sets at the edge where COUNT==5 is sampled
    req(4'hF, 32'hBFAF_000C, 32'd5);
    req(4'hF, 32'hBFAF_0008, 32'd0);
    idle(5);
    check_eq("timer_before_match", {31'h0, timer_int}, 32'h0);
    idle(1);
    check_eq("timer_at_match", {31'h0, timer_int}, 32'h1);
    req(4'h0, 32'hBFAF_0010, 32'h0);
    check_eq("rd_status", bus.rdata, 32'h1);
    req(4'h1, 32'hBFAF_0010, 32'h1);
    check_eq("timer_cleared", {31'h0, timer_int}, 32'h0);
    // Clear lands on the same edge as a match: set wins
    req(4'hF, 32'hBFAF_000C, 32'd200);
    req(4'hF, 32'hBFAF_0008, 32'd198);
    check_eq("timer_pre_coincide", {31'h0, timer_int}, 32'h0);
    idle(2);
    req(4'h1, 32'hBFAF_0010, 32'h1);
    check_eq("timer_set_beats_clr", {31'h0, timer_int}, 32'h1);
`else
    req(4'hF, 32'hBFAF_0008, 32'd5);
    req(4'h0, 32'hBFAF_0008, 32'h0);
    check_eq("rd_count_off", bus.rdata, 32'h0);
    req(4'h0, 32'hBFAF_0010, 32'h0);
    check_eq("rd_status_off", bus.rdata, 32'h0);
    begin
      logic seen_int;
      seen_int = 1'b0;
      for (int i = 0; i < 100; i++) begin
        idle(1);
        if (timer_int !== 1'b0) seen_int = 1'b1;
      end
      check_eq("timer_int_off", {31'h0, seen_int}, 32'h0);
    end
`endif

    // Reset mid-operation: make rdata nonzero first, then read under reset
    req(4'h0, 32'h0000_0100, 32'h0);
    check_eq("pre_rst_rd", bus.rdata, 32'hDEAD_55EF);
    rst = 1'b1;
    req(4'h0, 32'h0000_0104, 32'h0);
    check_eq("rst_mid_rdata", bus.rdata, 32'h0);
    check_eq("rst_mid_led", {16'h0, led}, 32'h0);
    // A write sampled with reset is dropped
    req(4'hF, 32'h0000_0104, 32'h0);
    rst = 1'b0;
    req(4'h0, 32'h0000_0104, 32'h0);
    check_eq("rst_wr_dropped", bus.rdata, 32'h0102_0304);
    req(4'h0, 32'h0000_0100, 32'h0);
    check_eq("ram_kept_over_rst", bus.rdata, 32'hDEAD_55EF);
    req(4'h0, 32'hBFAF_0000, 32'h0);
    check_eq("rst_scratch", bus.rdata, 32'h0);
`ifdef SRAM_RESP_TIMER_EN
    req(4'h0, 32'hBFAF_000C, 32'h0);
    check_eq("rst_compare", bus.rdata, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
